// File: rtl/memory_stage_if.sv
// MEM-stage bus: EX/MEM control and data going in, branch decision and
// MEM/WB register contents coming out. The master drives the EX/MEM side,
// and memory_stage connects through the slave modport.
interface memory_stage_if #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5
);
   logic              ALUzero_MEM;
   logic              RegWrite_MEM;
   logic              Branch_MEM;
   logic              Uncondbranch_MEM;
   logic              MemRead_MEM;
   logic              MemWrite_MEM;
   logic              Mem2Reg_MEM;
   logic [RD_W-1:0]   RD_MEM;
   logic [DATA_W-1:0] RegOutB_MEM;
   logic [DATA_W-1:0] ALUout_MEM;
   logic [DATA_W-1:0] PCtarget_MEM;

   logic              PCSrc;
   logic [DATA_W-1:0] PCtarget;
   logic [RD_W-1:0]   RD_WB;
   logic [DATA_W-1:0] ALUout_WB;
   logic [DATA_W-1:0] ReadData_WB;
   logic              RegWrite_WB;
   logic              Mem2Reg_WB;

   modport master (
      output ALUzero_MEM, RegWrite_MEM, Branch_MEM, Uncondbranch_MEM,
             MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, RD_MEM,
             RegOutB_MEM, ALUout_MEM, PCtarget_MEM,
      input  PCSrc, PCtarget, RD_WB, ALUout_WB, ReadData_WB,
             RegWrite_WB, Mem2Reg_WB
   );

   modport slave (
      input  ALUzero_MEM, RegWrite_MEM, Branch_MEM, Uncondbranch_MEM,
             MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, RD_MEM,
             RegOutB_MEM, ALUout_MEM, PCtarget_MEM,
      output PCSrc, PCtarget, RD_WB, ALUout_WB, ReadData_WB,
             RegWrite_WB, Mem2Reg_WB
   );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 64-bit pipelined CPU: data memory, branch resolution
// and the MEM/WB pipeline register.
// Every data-memory word starts at zero at time 0.
// Reset (resetl, active-high, asynchronous) clears the MEM/WB register and
// blocks stores. Memory contents are kept across reset.
module memory_stage #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int DEPTH  = 1024
) (
   input  logic            clk,
   input  logic            resetl,
   memory_stage_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: {DATA_W{1'b0}}};

   logic [IDX_W-1:0]  idx_s;
   logic              unused_addr_s;
   logic              pcsrc_s;

   logic [RD_W-1:0]   rd_wb_d,        rd_wb_q;
   logic [DATA_W-1:0] aluout_wb_d,    aluout_wb_q;
   logic [DATA_W-1:0] readdata_wb_d,  readdata_wb_q;
   logic              regwrite_wb_d,  regwrite_wb_q;
   logic              mem2reg_wb_d,   mem2reg_wb_q;

   // The address is word-indexed. Upper bits wrap and are not used.
   assign idx_s         = bus.ALUout_MEM[IDX_W-1:0];
   assign unused_addr_s = ^bus.ALUout_MEM[DATA_W-1:IDX_W];

   // Branch decision back to fetch. This path is combinational and stays live during reset.
   always_comb begin
      pcsrc_s = (bus.Branch_MEM & bus.ALUzero_MEM) | bus.Uncondbranch_MEM;
   end

   assign bus.PCSrc    = pcsrc_s;
   assign bus.PCtarget = bus.PCtarget_MEM;

   // Store port. Stores are held off while reset is asserted.
   always_ff @(posedge clk) begin
      if (bus.MemWrite_MEM && !resetl) begin
         mem_q[idx_s] <= bus.RegOutB_MEM;
      end
   end

   // Next MEM/WB contents. The read sees the contents before this edge's store.
   always_comb begin
      rd_wb_d       = bus.RD_MEM;
      aluout_wb_d   = bus.ALUout_MEM;
      regwrite_wb_d = bus.RegWrite_MEM;
      mem2reg_wb_d  = bus.Mem2Reg_MEM;
      if (bus.MemRead_MEM) begin
         readdata_wb_d = mem_q[idx_s];
      end else begin
         readdata_wb_d = {DATA_W{1'b0}};
      end
   end

   // MEM/WB pipeline register. It loads every cycle and is cleared asynchronously by reset.
   always_ff @(posedge clk or posedge resetl) begin
      if (resetl) begin
         rd_wb_q       <= {RD_W{1'b0}};
         aluout_wb_q   <= {DATA_W{1'b0}};
         readdata_wb_q <= {DATA_W{1'b0}};
         regwrite_wb_q <= 1'b0;
         mem2reg_wb_q  <= 1'b0;
      end else begin
         rd_wb_q       <= rd_wb_d;
         aluout_wb_q   <= aluout_wb_d;
         readdata_wb_q <= readdata_wb_d;
         regwrite_wb_q <= regwrite_wb_d;
         mem2reg_wb_q  <= mem2reg_wb_d;
      end
   end

   assign bus.RD_WB       = rd_wb_q;
   assign bus.ALUout_WB   = aluout_wb_q;
   assign bus.ReadData_WB = readdata_wb_q;
   assign bus.RegWrite_WB = regwrite_wb_q;
   assign bus.Mem2Reg_WB  = mem2reg_wb_q;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage. Each stimulus cycle pushes the
// hand-computed MEM/WB contents it expects. A monitor pops one entry after
// each rising edge and compares it with the DUT outputs.
module tb_memory_stage;
   logic clk = 1'b0;
   logic resetl = 1'b1;

   memory_stage_if #(.DATA_W(64), .RD_W(5)) bus();

   memory_stage dut (
      .clk    (clk),
      .resetl (resetl),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] alu;
      logic [63:0] rdata;
      logic        rw;
      logic        m2r;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   // Monitor: after each rising edge, compare the MEM/WB outputs with the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("RD_WB",       {59'd0, bus.RD_WB},       {59'd0, mon_e.rd});
         chk("ALUout_WB",   bus.ALUout_WB,            mon_e.alu);
         chk("ReadData_WB", bus.ReadData_WB,          mon_e.rdata);
         chk("RegWrite_WB", {63'd0, bus.RegWrite_WB}, {63'd0, mon_e.rw});
         chk("Mem2Reg_WB",  {63'd0, bus.Mem2Reg_WB},  {63'd0, mon_e.m2r});
      end
   end

   // Apply one cycle of inputs at the falling edge, push the expectation and check the branch outputs.
   task automatic cyc(input logic rst_v,
                      input logic br, input logic uc, input logic z,
                      input logic rw, input logic mr, input logic mw, input logic m2r,
                      input logic [4:0] rd, input logic [63:0] b,
                      input logic [63:0] alu, input logic [63:0] pct,
                      input logic [4:0] e_rd, input logic [63:0] e_alu,
                      input logic [63:0] e_rdata, input logic e_rw, input logic e_m2r,
                      input logic e_pcsrc);
      @(negedge clk);
      resetl               = rst_v;
      bus.Branch_MEM       = br;
      bus.Uncondbranch_MEM = uc;
      bus.ALUzero_MEM      = z;
      bus.RegWrite_MEM     = rw;
      bus.MemRead_MEM      = mr;
      bus.MemWrite_MEM     = mw;
      bus.Mem2Reg_MEM      = m2r;
      bus.RD_MEM           = rd;
      bus.RegOutB_MEM      = b;
      bus.ALUout_MEM       = alu;
      bus.PCtarget_MEM     = pct;
      exp_q.push_back('{rd: e_rd, alu: e_alu, rdata: e_rdata, rw: e_rw, m2r: e_m2r});
      #1;
      chk("PCSrc",    {63'd0, bus.PCSrc}, {63'd0, e_pcsrc});
      chk("PCtarget", bus.PCtarget,       pct);
   endtask

   initial begin
      bus.Branch_MEM = 1'b0; bus.Uncondbranch_MEM = 1'b0; bus.ALUzero_MEM = 1'b0;
      bus.RegWrite_MEM = 1'b0; bus.MemRead_MEM = 1'b0; bus.MemWrite_MEM = 1'b0;
      bus.Mem2Reg_MEM = 1'b0; bus.RD_MEM = 5'd0; bus.RegOutB_MEM = 64'd0;
      bus.ALUout_MEM = 64'd0; bus.PCtarget_MEM = 64'd0;

      //   rst  br    uc    z     rw    mr    mw    m2r   rd     b            alu          pct           e_rd   e_alu        e_rdata      e_rw  e_m2r pcsrc
      // Two cycles in reset. A store to word 3 is attempted and must be suppressed.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  64'd99,      64'd3,       64'd0,        5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  64'd99,      64'd3,       64'd0,        5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b0);
      // Store 10 at word 1, then load it.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  64'd10,      64'd1,       64'd8,        5'd0,  64'd1,       64'd0,       1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2,  64'd0,       64'd1,       64'd8,        5'd2,  64'd1,       64'd10,      1'b1, 1'b1, 1'b0);
      // Store 44 at word 12, load it, then confirm word 1 is unchanged.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  64'd44,      64'd12,      64'd0,        5'd0,  64'd12,      64'd0,       1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 64'd0,       64'd12,      64'd0,        5'd10, 64'd12,      64'd44,      1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  64'd0,       64'd1,       64'd0,        5'd3,  64'd1,       64'd10,      1'b1, 1'b1, 1'b0);
      // Word 3 must still read zero because the store during reset was blocked.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  64'd0,       64'd3,       64'd0,        5'd4,  64'd3,       64'd0,       1'b1, 1'b1, 1'b0);
      // A read and write to the same word return the old data, and the new value lands.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  64'd77,      64'd1,       64'd0,        5'd5,  64'd1,       64'd10,      1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  64'd0,       64'd1,       64'd0,        5'd6,  64'd1,       64'd77,      1'b1, 1'b1, 1'b0);
      // Address wrap: 0x405 maps to word 5.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  64'h1234,    64'h405,     64'd0,        5'd0,  64'h405,     64'd0,       1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'd0,       64'd5,       64'd0,        5'd31, 64'd5,       64'h1234,    1'b1, 1'b1, 1'b0);
      // With MemRead low, the read data is forced to zero.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  64'd0,       64'd5,       64'd0,        5'd8,  64'd5,       64'd0,       1'b1, 1'b0, 1'b0);
      // Branch resolution.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'd0,       64'd0,       64'h69,       5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'd0,       64'd0,       64'h69,       5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  64'd0,       64'd0,       64'h420,      5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1,  64'd0,       64'h77,      64'h420,      5'd1,  64'h77,      64'd0,       1'b1, 1'b0, 1'b0);
      // Reset mid-cycle: the outputs clear at once, and the store to word 0x55 is suppressed.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9,  64'hAB,      64'h55,      64'h88,       5'd0,  64'd0,       64'd0,       1'b0, 1'b0, 1'b1);
      #2;
      resetl = 1'b1;
      #1;
      chk("RD_WB_async_rst",       {59'd0, bus.RD_WB},       64'd0);
      chk("ALUout_WB_async_rst",   bus.ALUout_WB,            64'd0);
      chk("RegWrite_WB_async_rst", {63'd0, bus.RegWrite_WB}, 64'd0);
      chk("PCSrc_in_rst",          {63'd0, bus.PCSrc},       64'd1);
      // The first edge after reset releases captures the inputs normally. Word 0x55 still reads zero.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 64'd0,       64'h55,      64'd0,        5'd12, 64'h55,      64'd0,       1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
      #3;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
